// File: rtl/cp0_pkg.sv
// Shared CP0 constants for the interrupt/exception controller: register
// numbers, ExcCode values, Status bit positions and the per-cycle event kind.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LSB = 8;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_ERET = 2'd1,
    EV_EXC  = 2'd2,
    EV_INT  = 2'd3
  } cp0_event_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for the asynchronous external interrupt lines.
// Each line gets its own STAGES-deep shift chain; the last flop feeds Cause.IP.
module irq_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      logic [STAGES-1:0] shift_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) shift_reg <= '0;
        else     shift_reg <= {shift_reg[STAGES-2:0], d[gi]};
      end

      assign q[gi] = shift_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: Status/Cause/EPC/Count/Compare, fixed
// priority eret > overflow > syscall > interrupt, combinational redirect.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ     = 6,
  parameter logic [31:0] IBASE       = 32'h0000_0008,
  parameter bit          VECTORED    = 1'b1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               Clk,
  input  logic               Clrn,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        pc,
  input  logic               exc_ov,
  input  logic               exc_sys,
  input  logic               eret,
  input  logic               mtc0,
  input  logic [4:0]         cp0_sel,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               take,
  output logic [31:0]        redir_pc,
  output logic               exl
);

  localparam int NI = NUM_IRQ + 1;

  logic          ie_reg, exl_reg, timer_reg;
  logic [NI-1:0] im_reg;
  logic [4:0]    exc_code_reg;
  logic [31:0]   epc_reg, count_reg, compare_reg;

  logic [NUM_IRQ-1:0] irq_synced;
  logic [NI-1:0]      ip, pend;
  logic               int_req, found, wr_en;
  logic [31:0]        win_idx, status_rd, cause_rd;
  logic [4:0]         exc_code_next;
  cp0_event_e         ev;

  irq_sync #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
    .clk (Clk),
    .rst (Clrn),
    .d   (irq),
    .q   (irq_synced)
  );

  assign ip      = {timer_reg, irq_synced};
  assign pend    = ip & im_reg;
  assign int_req = ie_reg & ~exl_reg & (|pend);
  assign exl     = exl_reg;

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (pend[i] && !found) begin
        win_idx = 32'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    if (eret)                  ev = EV_ERET;
    else if (exc_ov | exc_sys) ev = EV_EXC;
    else if (int_req)          ev = EV_INT;
    else                       ev = EV_NONE;
  end

  assign exc_code_next = exc_ov ? EXC_OV : (exc_sys ? EXC_SYS : EXC_INT);
  assign take          = (ev != EV_NONE);
  // A taken redirect squashes the current instruction, including its mtc0.
  assign wr_en         = mtc0 & ~take;

  always_comb begin
    redir_pc = IBASE;
    if (ev == EV_ERET)
      redir_pc = epc_reg;
    else if (ev == EV_INT && VECTORED)
      redir_pc = IBASE + ((win_idx + 32'd1) << 5);
  end

  always_comb begin
    status_rd                   = '0;
    status_rd[ST_IE]            = ie_reg;
    status_rd[ST_EXL]           = exl_reg;
    status_rd[ST_IM_LSB +: NI]  = im_reg;
    cause_rd                    = '0;
    cause_rd[6:2]               = exc_code_reg;
    cause_rd[ST_IM_LSB +: NI]   = ip;
  end

  always_comb begin
    case (cp0_sel)
      CP0_COUNT:   rdata = count_reg;
      CP0_COMPARE: rdata = compare_reg;
      CP0_STATUS:  rdata = status_rd;
      CP0_CAUSE:   rdata = cause_rd;
      CP0_EPC:     rdata = epc_reg;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Clrn) begin
    if (Clrn) begin
      ie_reg       <= 1'b0;
      exl_reg      <= 1'b0;
      im_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
      count_reg    <= '0;
      compare_reg  <= 32'hFFFF_FFFF;
      timer_reg    <= 1'b0;
    end else begin
      count_reg <= (wr_en && cp0_sel == CP0_COUNT) ? wdata : count_reg + 32'd1;

      // Writing Compare acknowledges the timer and wins over a same-cycle match.
      if (wr_en && cp0_sel == CP0_COMPARE) begin
        compare_reg <= wdata;
        timer_reg   <= 1'b0;
      end else if (count_reg == compare_reg) begin
        timer_reg <= 1'b1;
      end

      case (ev)
        EV_ERET: exl_reg <= 1'b0;
        EV_EXC, EV_INT: begin
          exl_reg      <= 1'b1;
          epc_reg      <= pc;
          exc_code_reg <= exc_code_next;
        end
        default: begin
          if (wr_en && cp0_sel == CP0_STATUS) begin
            ie_reg  <= wdata[ST_IE];
            exl_reg <= wdata[ST_EXL];
            im_reg  <= wdata[ST_IM_LSB +: NI];
          end
          if (wr_en && cp0_sel == CP0_EPC) epc_reg <= wdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: expectations are queued when stimulus is driven
// and popped against DUT outputs once they have settled.
module tb_cp0_intc;
  import cp0_pkg::*;

  localparam int          NUM_IRQ = 6;
  localparam logic [31:0] IBASE   = 32'h0000_0008;

  logic               Clk = 1'b0;
  logic               Clrn;
  logic [NUM_IRQ-1:0] irq;
  logic [31:0]        pc, wdata, rdata, redir_pc;
  logic               exc_ov, exc_sys, eret, mtc0, take, exl;
  logic [4:0]         cp0_sel;

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  cp0_intc #(
    .NUM_IRQ(NUM_IRQ), .IBASE(IBASE), .VECTORED(1'b1), .SYNC_STAGES(2)
  ) dut (
    .Clk(Clk), .Clrn(Clrn), .irq(irq), .pc(pc), .exc_ov(exc_ov),
    .exc_sys(exc_sys), .eret(eret), .mtc0(mtc0), .cp0_sel(cp0_sel),
    .wdata(wdata), .rdata(rdata), .take(take), .redir_pc(redir_pc), .exl(exl)
  );

  always #10 Clk = ~Clk;

  task automatic push_exp(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h required an expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] sel, input logic [31:0] e);
    cp0_sel = sel;
    push_exp(tag, e);
    #1;
    pop_check(rdata);
  endtask

  task automatic chk_take(input string tag, input logic t, input logic [31:0] r);
    push_exp({tag, "_take"}, {31'd0, t});
    if (t) push_exp({tag, "_redir"}, r);
    #1;
    pop_check({31'd0, take});
    if (t) pop_check(redir_pc);
  endtask

  task automatic chk_exl(input string tag, input logic e);
    push_exp(tag, {31'd0, e});
    #1;
    pop_check({31'd0, exl});
  endtask

  task automatic wr(input logic [4:0] sel, input logic [31:0] d);
    mtc0 = 1'b1; cp0_sel = sel; wdata = d;
    tick();
    mtc0 = 1'b0; wdata = '0;
  endtask

  initial begin
    Clrn = 1'b1; irq = '0; pc = '0; wdata = '0; exc_ov = 0; exc_sys = 0;
    eret = 0; mtc0 = 0; cp0_sel = '0;
    #3;
    // Reset state while Clrn is held
    chk_take("rst", 1'b0, IBASE);
    push_exp("rst_redir", IBASE); #1; pop_check(redir_pc);
    chk_exl("rst_exl", 1'b0);
    chk_reg("rst_status", CP0_STATUS, 32'h0);
    chk_reg("rst_cause", CP0_CAUSE, 32'h0);
    chk_reg("rst_epc", CP0_EPC, 32'h0);
    chk_reg("rst_count", CP0_COUNT, 32'h0);
    chk_reg("rst_compare", CP0_COMPARE, 32'hFFFF_FFFF);
    chk_reg("rst_unmapped", 5'd5, 32'h0);
    #20;
    Clrn = 1'b0;
    tick();

    // 1: vectored external interrupt, two-cycle synchroniser latency
    wr(CP0_STATUS, 32'h0000_0301);
    chk_reg("t1_status", CP0_STATUS, 32'h0000_0301);
    irq[1] = 1'b1; pc = 32'h0000_1000;
    chk_take("t1_lat0", 1'b0, '0);
    tick();
    chk_take("t1_lat1", 1'b0, '0);
    tick();
    chk_take("t1_int", 1'b1, IBASE + 32'h40);
    irq[1] = 1'b0;
    tick();
    chk_exl("t1_exl", 1'b1);
    chk_take("t1_blocked", 1'b0, '0);
    chk_reg("t1_epc", CP0_EPC, 32'h0000_1000);
    chk_reg("t1_cause", CP0_CAUSE, 32'h0000_0200);
    eret = 1'b1;
    chk_take("t1_eret", 1'b1, 32'h0000_1000);
    tick();
    eret = 1'b0;
    chk_exl("t1_eret_exl", 1'b0);
    chk_take("t1_idle", 1'b0, '0);

    // 2: overflow beats a pending interrupt, which follows the eret
    irq[0] = 1'b1;
    tick(); tick();
    exc_ov = 1'b1; pc = 32'h0000_2000;
    chk_take("t2_ov", 1'b1, IBASE);
    tick();
    exc_ov = 1'b0;
    chk_exl("t2_exl", 1'b1);
    chk_reg("t2_cause", CP0_CAUSE, 32'h0000_0130);
    chk_reg("t2_epc", CP0_EPC, 32'h0000_2000);
    eret = 1'b1;
    chk_take("t2_eret", 1'b1, 32'h0000_2000);
    tick();
    eret = 1'b0; pc = 32'h0000_3000;
    chk_take("t2_int", 1'b1, IBASE + 32'h20);
    tick();
    chk_reg("t2_int_cause", CP0_CAUSE, 32'h0000_0100);
    chk_reg("t2_int_epc", CP0_EPC, 32'h0000_3000);
    irq[0] = 1'b0;
    tick(); tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk_take("t2_quiet", 1'b0, '0);

    // 3: Count/Compare timer interrupt
    wr(CP0_STATUS, 32'h0000_4000);
    wr(CP0_COUNT, 32'd100);
    wr(CP0_COMPARE, 32'd105);
    chk_reg("t3_count", CP0_COUNT, 32'd101);
    tick(); tick(); tick(); tick();
    chk_reg("t3_match_cycle", CP0_CAUSE, 32'h0);
    tick();
    chk_reg("t3_ip_set", CP0_CAUSE, 32'h0000_4000);
    chk_take("t3_masked", 1'b0, '0);
    wr(CP0_STATUS, 32'h0000_4101);
    pc = 32'h0000_4000;
    chk_take("t3_timer", 1'b1, IBASE + 32'h20 * (NUM_IRQ + 1));
    tick();
    chk_exl("t3_exl", 1'b1);
    wr(CP0_COMPARE, 32'h0);
    chk_reg("t3_ip_clr", CP0_CAUSE, 32'h0);

    // 4: EXL blocks interrupts but not syscall; squashed mtc0
    irq[0] = 1'b1;
    tick(); tick();
    chk_take("t4_blocked", 1'b0, '0);
    exc_sys = 1'b1; pc = 32'h0000_5000;
    mtc0 = 1'b1; cp0_sel = CP0_STATUS; wdata = 32'h0;
    chk_take("t4_sys", 1'b1, IBASE);
    tick();
    exc_sys = 1'b0; mtc0 = 1'b0;
    chk_reg("t4_cause", CP0_CAUSE, 32'h0000_0120);
    chk_reg("t4_epc", CP0_EPC, 32'h0000_5000);
    chk_reg("t4_status_kept", CP0_STATUS, 32'h0000_4103);
    irq[0] = 1'b0;

    // 5: Count wrap, then reset in the middle of a handler
    wr(CP0_COUNT, 32'hFFFF_FFFE);
    chk_reg("t5_cnt_fe", CP0_COUNT, 32'hFFFF_FFFE);
    tick();
    chk_reg("t5_cnt_ff", CP0_COUNT, 32'hFFFF_FFFF);
    tick();
    chk_reg("t5_cnt_wrap", CP0_COUNT, 32'h0);
    Clrn = 1'b1;
    chk_take("t5_rst", 1'b0, '0);
    chk_exl("t5_rst_exl", 1'b0);
    chk_reg("t5_rst_status", CP0_STATUS, 32'h0);
    chk_reg("t5_rst_cause", CP0_CAUSE, 32'h0);
    chk_reg("t5_rst_epc", CP0_EPC, 32'h0);
    chk_reg("t5_rst_compare", CP0_COMPARE, 32'hFFFF_FFFF);
    chk_reg("t5_rst_count", CP0_COUNT, 32'h0);
    Clrn = 1'b0;
    tick();
    chk_reg("t5_count_run", CP0_COUNT, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
